// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the RV32I program counter, fetches each instruction over
// a req/valid handshake, presents it for one EXEC cycle, then picks the next PC
// from the decoder controls. HALT (ecall exit) and FAULT (fetch timeout or
// misaligned target) are terminal until reset.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             jal,
  input  logic             jalr,
  input  logic             branch,
  input  logic             is_ecall,
  input  logic             bcond,
  input  logic             ecall_halt,
  input  logic [31:0]      imm,
  input  logic [31:0]      jalr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [CNT_W-1:0] retired,
  output logic             is_halted,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic [CNT_W-1:0]  retired_q;
  logic [WAIT_W-1:0] wait_q;
  logic              req_q;
  logic              ivalid_q;
  logic              halted_q;
  logic              fault_q;
  logic [1:0]        code_q;

  logic [31:0]       npc_d;
  logic [WAIT_W-1:0] wait_d;

  // Next-PC selection for the EXEC cycle (jalr > jal > taken branch > pc+4);
  // the jalr target has bit 0 forced low.
  always_comb begin
    npc_d = pc_q + 32'd4;
    if (jalr) begin
      npc_d = jalr_target & 32'hFFFF_FFFE;
    end else if (jal || (branch && bcond)) begin
      npc_d = pc_q + imm;
    end
    wait_d = wait_q + WAIT_W'(1);
  end

  // Sequencer FSM; every status output is a register updated with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      wait_q    <= '0;
      req_q     <= 1'b0;
      ivalid_q  <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          wait_q  <= '0;
        end
        S_FETCH: begin
          if (imem_valid) begin
            instr_q  <= imem_rdata;
            wait_q   <= '0;
            req_q    <= 1'b0;
            ivalid_q <= 1'b1;
            state_q  <= S_EXEC;
          end else if (wait_d == WAIT_LIMIT) begin
            wait_q  <= '0;
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            code_q  <= 2'b01;
            state_q <= S_FAULT;
          end else begin
            wait_q <= wait_d;
          end
        end
        S_EXEC: begin
          ivalid_q <= 1'b0;
          if (npc_d[1:0] != 2'b00) begin
            fault_q <= 1'b1;
            code_q  <= 2'b10;
            state_q <= S_FAULT;
          end else begin
            pc_q      <= npc_d;
            retired_q <= retired_q + CNT_W'(1);
            if (is_ecall && ecall_halt) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_HALT, S_FAULT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = ivalid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign retired     = retired_q;
  assign is_halted   = halted_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: instruction-level reference model driven alongside random
// and directed stimulus; a negedge process compares all outputs each cycle.
module tb_pc_sequencer;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam int          MAXW = 4;
  localparam int          CW   = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_valid = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   instr;
  logic          instr_valid;
  logic          d_jal = 1'b0, d_jalr = 1'b0, d_branch = 1'b0, d_ecall = 1'b0;
  logic          d_bcond = 1'b0, d_halt = 1'b0;
  logic [31:0]   d_imm = '0, d_jt = '0;
  logic [31:0]   pc, pc_plus4;
  logic [CW-1:0] retired;
  logic          is_halted, fault;
  logic [1:0]    fault_code;

  pc_sequencer #(.RESET_PC(RPC), .CNT_W(CW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .jal(d_jal), .jalr(d_jalr), .branch(d_branch), .is_ecall(d_ecall),
    .bcond(d_bcond), .ecall_halt(d_halt), .imm(d_imm), .jalr_target(d_jt),
    .pc(pc), .pc_plus4(pc_plus4), .retired(retired),
    .is_halted(is_halted), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model state (what the outputs must show right now)
  logic [31:0] m_pc, m_instr;
  int unsigned m_ret;
  bit m_req, m_ivalid, m_halt, m_fault, live;
  logic [1:0] m_code;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      if (m_req) check("imem_addr", imem_addr, m_pc);
      check("instr_valid", {31'b0, instr_valid}, {31'b0, m_ivalid});
      check("instr", instr, m_instr);
      check("pc", pc, m_pc);
      check("pc_plus4", pc_plus4, m_pc + 32'd4);
      check("retired", {24'b0, retired}, m_ret);
      check("is_halted", {31'b0, is_halted}, {31'b0, m_halt});
      check("fault", {31'b0, fault}, {31'b0, m_fault});
      check("fault_code", {30'b0, fault_code}, {30'b0, m_code});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic junk_ctrl;
    d_jal = 1'($urandom); d_jalr = 1'($urandom); d_branch = 1'($urandom);
    d_ecall = 1'($urandom); d_bcond = 1'($urandom); d_halt = 1'($urandom);
    d_imm = $urandom; d_jt = $urandom;
  endtask

  // Called one time unit after a clock edge; asserts reset mid-cycle.
  task automatic do_reset;
    imem_valid = 1'b1;
    imem_rdata = $urandom;
    #2 reset = 1'b0;
    #1;
    m_pc = RPC; m_instr = '0; m_ret = 0;
    m_req = 0; m_ivalid = 0; m_halt = 0; m_fault = 0; m_code = 2'b00;
    check("rst_pc", pc, RPC);
    check("rst_retired", {24'b0, retired}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr", instr, 32'd0);
    live = 1;
    tick;
    reset = 1'b1;
    imem_valid = 1'($urandom);
    tick;
    m_req = 1;
  endtask

  // One instruction from the cycle FETCH begins: w wait cycles, then EXEC.
  task automatic run_instr(input int w, input logic [31:0] word,
                           input bit j, input bit jr, input bit br, input bit bc,
                           input bit ec, input bit eh,
                           input logic [31:0] im, input logic [31:0] jt);
    logic [31:0] t;
    for (int k = 0; k < 100000; k++) begin
      imem_valid = (k == w);
      imem_rdata = (k == w) ? word : $urandom;
      junk_ctrl;
      tick;
      if (k == w) break;
      if (k + 1 == MAXW) begin
        m_req = 0; m_fault = 1; m_code = 2'b01;
        return;
      end
    end
    m_req = 0; m_ivalid = 1; m_instr = word;
    d_jal = j; d_jalr = jr; d_branch = br; d_bcond = bc;
    d_ecall = ec; d_halt = eh; d_imm = im; d_jt = jt;
    imem_valid = 1'($urandom); imem_rdata = $urandom;
    tick;
    m_ivalid = 0;
    if (jr)                  t = (jt / 2) * 2;
    else if (j || (br && bc)) t = m_pc + im;
    else                      t = m_pc + 32'd4;
    if (t % 4 != 0) begin
      m_fault = 1; m_code = 2'b10;
    end else begin
      m_pc = t;
      m_ret = (m_ret + 1) % (1 << CW);
      if (ec && eh) m_halt = 1;
      else m_req = 1;
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    int c0, kind, rret;
    live = 0;
    #1;
    do_reset;

    // Zero-wait NOPs from the reset PC
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", imem_addr, RPC + 32'(4 * i));
      run_instr(0, NOP, 0, 0, 0, 0, 0, 0, '0, '0);
    end
    check("three_retired", {24'b0, retired}, 32'd3);
    check("three_pc", pc, 32'h10C);

    // Control flow from 0x200
    run_instr(0, 32'h1, 1, 0, 0, 0, 0, 0, 32'h0000_00F4, '0);
    check("to_200", pc, 32'h200);
    run_instr(0, 32'h2, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, '0);
    check("jal_m8", pc, 32'h1F8);
    run_instr(0, 32'h3, 0, 0, 1, 1, 0, 0, 32'h10, '0);
    check("br_taken", pc, 32'h208);
    run_instr(0, 32'h4, 0, 1, 0, 0, 0, 0, 32'h99, 32'h305);
    check("jalr_305", pc, 32'h304);
    run_instr(0, 32'h5, 0, 0, 1, 0, 0, 0, 32'h40, '0);
    check("br_not_taken", pc, 32'h308);

    // Three wait states: five cycles per instruction
    c0 = cyc;
    run_instr(3, NOP, 0, 0, 0, 0, 0, 0, '0, '0);
    check("wait3_len", 32'(cyc - c0), 32'd5);

    // Random traffic, long enough to wrap the 8-bit retired counter
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        5:       run_instr($urandom_range(0, 3), $urandom, 1, 0, 1'($urandom), 1'($urandom), 0, 0,
                           $urandom & 32'hFFFF_FFFC, $urandom);
        6:       run_instr($urandom_range(0, 3), $urandom, 1'($urandom), 1, 1'($urandom), 1'($urandom), 0, 0,
                           $urandom, $urandom & 32'hFFFF_FFFD);
        7, 8:    run_instr($urandom_range(0, 3), $urandom, 0, 0, 1, 1'($urandom), 0, 0,
                           $urandom & 32'hFFFF_FFFC, $urandom);
        4:       run_instr($urandom_range(0, 3), $urandom, 0, 0, 0, 1'($urandom), 1, 0,
                           $urandom, $urandom);
        default: run_instr($urandom_range(0, 3), $urandom, 0, 0, 0, 1'($urandom), 0, 0,
                           $urandom, $urandom);
      endcase
    end

    // ecall at 0x40: non-halting then halting
    run_instr(0, 32'h6, 0, 1, 0, 0, 0, 0, '0, 32'h40);
    check("to_40", pc, 32'h40);
    run_instr(1, 32'h73, 0, 0, 0, 0, 1, 0, '0, '0);
    check("ecall_nohalt_pc", pc, 32'h44);
    check("ecall_nohalt_req", {31'b0, imem_req}, 32'd1);
    run_instr(0, 32'h7, 0, 1, 0, 0, 0, 0, '0, 32'h40);
    rret = m_ret;
    run_instr(0, 32'h73, 0, 0, 0, 0, 1, 1, '0, '0);
    for (int i = 0; i < 6; i++) begin
      imem_valid = 1'($urandom); imem_rdata = $urandom; junk_ctrl;
      tick;
    end
    check("halt_flag", {31'b0, is_halted}, 32'd1);
    check("halt_pc", pc, 32'h44);
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_retired", {24'b0, retired}, 32'((rret + 1) % 256));

    // Misaligned jump target from pc 0
    do_reset;
    run_instr(0, 32'h8, 1, 0, 0, 0, 0, 0, 32'hFFFF_FF00, '0);
    check("to_0", pc, 32'h0);
    run_instr(0, 32'h9, 1, 0, 0, 0, 0, 0, 32'h6, '0);
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'($urandom); junk_ctrl;
      tick;
    end
    check("mis_fault", {31'b0, fault}, 32'd1);
    check("mis_code", {30'b0, fault_code}, 32'd2);
    check("mis_pc", pc, 32'h0);
    check("mis_retired", {24'b0, retired}, 32'd1);

    // Fetch timeout: memory never responds
    do_reset;
    c0 = cyc;
    run_instr(1000, NOP, 0, 0, 0, 0, 0, 0, '0, '0);
    check("tmo_len", 32'(cyc - c0), 32'(MAXW));
    imem_valid = 1'b1;
    tick;
    tick;
    check("tmo_fault", {31'b0, fault}, 32'd1);
    check("tmo_code", {30'b0, fault_code}, 32'd1);
    check("tmo_req", {31'b0, imem_req}, 32'd0);
    check("tmo_pc", pc, RPC);

    // Reset in the middle of a FETCH with a response in flight
    do_reset;
    run_instr(0, NOP, 0, 0, 0, 0, 0, 0, '0, '0);
    run_instr(2, NOP, 0, 0, 0, 0, 0, 0, '0, '0);
    do_reset;
    run_instr(0, NOP, 0, 0, 0, 0, 0, 0, '0, '0);
    run_instr(1, NOP, 0, 0, 0, 0, 0, 0, '0, '0);
    check("post_rst_pc", pc, 32'h108);
    check("post_rst_retired", {24'b0, retired}, 32'd2);

    live = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
